// File: rtl/mem_arbiter.sv
// Single-beat bus arbiter sharing one memory port between instruction fetch and data access.
// Alternates grants under contention, discards flushed fetches and aborts unacknowledged transactions.
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_ack_o,
  output logic [DATA_W-1:0] if_rdata_o,
  input  logic              mem_req_i,
  input  logic              mem_we_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [3:0]        mem_sel_i,
  input  logic [DATA_W-1:0] mem_wdata_i,
  output logic              mem_ack_o,
  output logic [DATA_W-1:0] mem_rdata_o,
  output logic              mem_err_o,
  output logic              if_err_o,
  output logic              stallreq_if_o,
  output logic              stallreq_mem_o,
  output logic              bus_req_o,
  output logic              bus_we_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [3:0]        bus_sel_o,
  output logic [DATA_W-1:0] bus_wdata_o,
  input  logic              bus_ack_i,
  input  logic [DATA_W-1:0] bus_rdata_i
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state;
  state_t           state_nxt;
  logic             owner_mem;
  logic             last_mem;
  logic             discard;
  logic [CNT_W-1:0] wdog;

  logic grant_mem;
  logic grant_if;
  logic kill;
  logic timeout;
  logic discard_nxt;

  assign stallreq_if_o  = if_req_i & ~if_ack_o;
  assign stallreq_mem_o = mem_req_i & ~mem_ack_o;
  assign discard_nxt    = discard | kill;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // MEM wins a tie unless it was served last; a flush hides the fetch request for that cycle.
  always_comb begin
    state_nxt = state;
    grant_mem = 1'b0;
    grant_if  = 1'b0;
    kill      = 1'b0;
    timeout   = 1'b0;
    case (state)
      IDLE: begin
        grant_mem = mem_req_i & (~(if_req_i & ~flush_i) | ~last_mem);
        grant_if  = if_req_i & ~flush_i & ~grant_mem;
        if (grant_mem | grant_if) state_nxt = BUSY;
      end
      BUSY: begin
        kill    = ~owner_mem & (flush_i | ~if_req_i);
        timeout = ~bus_ack_i & (wdog >= CNT_W'(TIMEOUT - 1));
        if (bus_ack_i | timeout) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Requester acks are registered on the BUSY->DONE edge so they are high exactly during DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_mem   <= 1'b0;
      last_mem    <= 1'b0;
      discard     <= 1'b0;
      wdog        <= '0;
      bus_req_o   <= 1'b0;
      bus_we_o    <= 1'b0;
      bus_addr_o  <= '0;
      bus_sel_o   <= 4'h0;
      bus_wdata_o <= '0;
      if_ack_o    <= 1'b0;
      if_err_o    <= 1'b0;
      if_rdata_o  <= '0;
      mem_ack_o   <= 1'b0;
      mem_err_o   <= 1'b0;
      mem_rdata_o <= '0;
    end else begin
      if_ack_o  <= 1'b0;
      if_err_o  <= 1'b0;
      mem_ack_o <= 1'b0;
      mem_err_o <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_mem | grant_if) begin
            owner_mem   <= grant_mem;
            wdog        <= '0;
            bus_req_o   <= 1'b1;
            bus_we_o    <= grant_mem & mem_we_i;
            bus_addr_o  <= grant_mem ? mem_addr_i : if_addr_i;
            bus_sel_o   <= grant_mem ? mem_sel_i : 4'hF;
            bus_wdata_o <= grant_mem ? mem_wdata_i : '0;
          end
        end
        BUSY: begin
          if (wdog != {CNT_W{1'b1}}) wdog <= wdog + CNT_W'(1);
          discard <= discard_nxt;
          if (state_nxt == DONE) begin
            bus_req_o <= 1'b0;
            if (owner_mem) begin
              mem_ack_o <= 1'b1;
              mem_err_o <= timeout;
              if (bus_ack_i) mem_rdata_o <= bus_rdata_i;
            end else if (!discard_nxt) begin
              if_ack_o <= 1'b1;
              if_err_o <= timeout;
              if (bus_ack_i) if_rdata_o <= bus_rdata_i;
            end
          end
        end
        DONE: begin
          last_mem <= owner_mem;
          discard  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: randomized requesters, a memory slave with address-selected
// wait states, and a transaction-level model that predicts every requester response.
module tb_mem_arbiter;
  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 16;
  localparam int CNT_W   = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic              flush_i;
  logic              if_req_i;
  logic [ADDR_W-1:0] if_addr_i;
  logic              if_ack_o;
  logic [DATA_W-1:0] if_rdata_o;
  logic              mem_req_i;
  logic              mem_we_i;
  logic [ADDR_W-1:0] mem_addr_i;
  logic [3:0]        mem_sel_i;
  logic [DATA_W-1:0] mem_wdata_i;
  logic              mem_ack_o;
  logic [DATA_W-1:0] mem_rdata_o;
  logic              mem_err_o;
  logic              if_err_o;
  logic              stallreq_if_o;
  logic              stallreq_mem_o;
  logic              bus_req_o;
  logic              bus_we_o;
  logic [ADDR_W-1:0] bus_addr_o;
  logic [3:0]        bus_sel_o;
  logic [DATA_W-1:0] bus_wdata_o;
  logic              bus_ack_i;
  logic [DATA_W-1:0] bus_rdata_i;

  mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .flush_i(flush_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_ack_o(if_ack_o), .if_rdata_o(if_rdata_o),
    .mem_req_i(mem_req_i), .mem_we_i(mem_we_i), .mem_addr_i(mem_addr_i), .mem_sel_i(mem_sel_i),
    .mem_wdata_i(mem_wdata_i), .mem_ack_o(mem_ack_o), .mem_rdata_o(mem_rdata_o),
    .mem_err_o(mem_err_o), .if_err_o(if_err_o),
    .stallreq_if_o(stallreq_if_o), .stallreq_mem_o(stallreq_mem_o),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o), .bus_sel_o(bus_sel_o),
    .bus_wdata_o(bus_wdata_o), .bus_ack_i(bus_ack_i), .bus_rdata_i(bus_rdata_i)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic        chk_data;
  } exp_t;

  int          checks = 0;
  int          failures = 0;
  exp_t        if_exp[$];
  exp_t        mem_exp[$];
  exp_t        mon_e;
  logic [31:0] ref_mem[logic [31:0]];
  logic [31:0] slv_mem[logic [31:0]];
  logic [31:0] model_if_rdata;
  bit          grant_log[$];
  logic [36:0] rise_fields;
  logic        prev_req;
  int          run_len;
  int          last_len;
  int          slv_cnt;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  // Background contents of any word never written.
  function automatic logic [31:0] dflt(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1234_5678;
  endfunction

  function automatic logic [31:0] rom(input logic [31:0] a);
    return (a == 32'h100) ? 32'h0000_0013 : dflt(a);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
    for (int b = 0; b < 4; b++) if (s[b]) o[8*b +: 8] = n[8*b +: 8];
    return o;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
  endfunction

  // Slave wait states come from the address: page F never answers, page E answers in BUSY cycle 16.
  function automatic int wait_of(input logic [31:0] a);
    if (a[11:8] == 4'hF) return 1000;
    if (a[11:8] == 4'hE) return TIMEOUT - 1;
    return int'(a[6:4]);
  endfunction

  function automatic logic [31:0] rnd_if_addr();
    return {22'd0, 8'($urandom_range(0, 255)), 2'b00};
  endfunction

  function automatic logic [31:0] rnd_mem_addr();
    return 32'h2000 | {26'd0, 4'($urandom_range(0, 15)), 2'b00};
  endfunction

  // Memory slave plus bus observer: logs grant order and request length, checks field stability.
  initial begin
    bus_ack_i   = 1'b0;
    bus_rdata_i = '0;
    slv_cnt     = 0;
    prev_req    = 1'b0;
    run_len     = 0;
    last_len    = 0;
    rise_fields = '0;
    slv_mem[32'h100] = 32'h0000_0013;
    forever begin
      @(negedge clk or posedge rst);
      if (rst) begin
        bus_ack_i = 1'b0;
        slv_cnt   = 0;
        prev_req  = 1'b0;
        run_len   = 0;
      end else begin
        if (bus_req_o && !prev_req) begin
          grant_log.push_back(bus_addr_o >= 32'h2000);
          rise_fields = {bus_we_o, bus_sel_o, bus_addr_o};
        end
        if (bus_req_o) run_len++;
        else if (prev_req) begin
          last_len = run_len;
          run_len  = 0;
        end
        prev_req = bus_req_o;
        if (bus_ack_i) begin
          bus_ack_i   = 1'b0;
          bus_rdata_i = '0;
          slv_cnt     = 0;
        end else if (bus_req_o) begin
          if (slv_cnt == wait_of(bus_addr_o)) begin
            checkOutput("bus_stable", {27'd0, bus_we_o, bus_sel_o, bus_addr_o}, {27'd0, rise_fields});
            if (bus_addr_o < 32'h1000)
              checkOutput("bus_fetch_fields", {bus_we_o, bus_sel_o, bus_wdata_o}, {1'b0, 4'hF, 32'h0});
            bus_ack_i = 1'b1;
            if (bus_we_o) begin
              slv_mem[bus_addr_o] = merge(slv_mem.exists(bus_addr_o) ? slv_mem[bus_addr_o] : dflt(bus_addr_o),
                                          bus_wdata_o, bus_sel_o);
              bus_rdata_i = 32'h0;
            end else begin
              bus_rdata_i = slv_mem.exists(bus_addr_o) ? slv_mem[bus_addr_o] : dflt(bus_addr_o);
            end
          end else begin
            slv_cnt++;
          end
        end else begin
          slv_cnt = 0;
        end
      end
    end
  end

  // Scoreboard monitor: every requester ack pops the oldest prediction for that requester.
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      if (if_ack_o) begin
        if (if_exp.size() == 0) checkOutput("if_ack_unexpected", 1, 0);
        else begin
          mon_e = if_exp.pop_front();
          checkOutput("if_err", if_err_o, mon_e.err);
          if (!mon_e.err) checkOutput("if_rdata", if_rdata_o, mon_e.rdata);
        end
      end
      if (mem_ack_o) begin
        if (mem_exp.size() == 0) checkOutput("mem_ack_unexpected", 1, 0);
        else begin
          mon_e = mem_exp.pop_front();
          checkOutput("mem_err", mem_err_o, mon_e.err);
          if (!mon_e.err && mon_e.chk_data) checkOutput("mem_rdata", mem_rdata_o, mon_e.rdata);
        end
      end
      if (if_ack_o || mem_ack_o || if_err_o || mem_err_o)
        checkOutput("ack_err_exclusive", {if_err_o & ~if_ack_o, mem_err_o & ~mem_ack_o, if_ack_o & mem_ack_o}, 0);
    end
  end

  task automatic waitAck(input bit is_mem);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(is_mem ? mem_ack_o : if_ack_o) && n < 100);
    checkOutput(is_mem ? "mem_ack_wait" : "if_ack_wait", is_mem ? mem_ack_o : if_ack_o, 1);
    @(posedge clk);
    #1;
    if (is_mem) mem_req_i = 1'b0;
    else        if_req_i  = 1'b0;
  endtask

  // Issue one transaction and record what the requester must eventually see.
  task automatic applyStimulus(input bit is_mem, input bit we, input logic [31:0] a,
                               input logic [3:0] sel, input logic [31:0] wd);
    exp_t e;
    e.err      = (wait_of(a) >= TIMEOUT);
    e.chk_data = !we;
    e.rdata    = '0;
    if (is_mem) begin
      if (we) begin
        if (!e.err) ref_mem[a] = merge(ref_rd(a), wd, sel);
      end else begin
        e.rdata = ref_rd(a);
      end
      mem_exp.push_back(e);
      mem_we_i    = we;
      mem_addr_i  = a;
      mem_sel_i   = sel;
      mem_wdata_i = wd;
      mem_req_i   = 1'b1;
    end else begin
      e.rdata = rom(a);
      if (!e.err) model_if_rdata = e.rdata;
      if_exp.push_back(e);
      if_addr_i = a;
      if_req_i  = 1'b1;
    end
    waitAck(is_mem);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_ctrl"}, {if_ack_o, if_err_o, mem_ack_o, mem_err_o, stallreq_if_o, stallreq_mem_o,
                                 bus_req_o, bus_we_o, bus_sel_o}, 0);
    checkOutput({tag, "_rdata"}, {if_rdata_o, mem_rdata_o}, 0);
    checkOutput({tag, "_bus"}, {bus_addr_o, bus_wdata_o}, 0);
  endtask

  task automatic waitBusReq(input logic level, input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (bus_req_o !== level && n < 50);
    checkOutput(name, bus_req_o, level);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL global_timeout actual=running expected=finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin
    exp_t e;
    rst = 1'b1; flush_i = 1'b0;
    if_req_i = 1'b0; if_addr_i = '0;
    mem_req_i = 1'b0; mem_we_i = 1'b0; mem_addr_i = '0; mem_sel_i = '0; mem_wdata_i = '0;
    model_if_rdata = '0;
    repeat (2) @(negedge clk);
    checkAllZero("reset");
    @(posedge clk); #1 rst = 1'b0;

    // Both requesters from reset: MEM first, IF keeps stalling until its own ack.
    $display("[TB] simultaneous requests from reset");
    grant_log.delete();
    fork
      applyStimulus(1, 1, 32'h2000, 4'h3, 32'hDEAD_BEEF);
      applyStimulus(0, 0, 32'h044, 4'hF, 32'h0);
      begin
        int n = 0;
        do begin @(negedge clk); n++; end while (!mem_ack_o && n < 100);
        checkOutput("t2_stall_if_during_mem_ack", stallreq_if_o, 1);
      end
    join
    checkOutput("t2_grant_count", grant_log.size(), 2);
    if (grant_log.size() == 2) checkOutput("t2_grant_order", {grant_log[0], grant_log[1]}, 2'b10);
    applyStimulus(1, 0, 32'h2000, 4'hF, 32'h0);

    // Zero-wait fetch: bus request one cycle after the request, ack the cycle after that.
    $display("[TB] zero-wait fetch latency");
    e.rdata = 32'h0000_0013; e.err = 1'b0; e.chk_data = 1'b1;
    if_exp.push_back(e);
    model_if_rdata = 32'h0000_0013;
    if_addr_i = 32'h100; if_req_i = 1'b1;
    @(negedge clk);
    checkOutput("t1_req_cycle", {bus_req_o, if_ack_o, stallreq_if_o, stallreq_mem_o}, 4'b0010);
    @(negedge clk);
    checkOutput("t1_bus_cycle", {bus_req_o, bus_we_o, bus_sel_o, if_ack_o}, {1'b1, 1'b0, 4'hF, 1'b0});
    checkOutput("t1_bus_addr_wdata", {bus_addr_o, bus_wdata_o}, {32'h100, 32'h0});
    @(negedge clk);
    checkOutput("t1_ack_cycle", {if_ack_o, stallreq_if_o, bus_req_o}, 3'b100);
    checkOutput("t1_if_rdata", if_rdata_o, 32'h13);
    @(posedge clk); #1 if_req_i = 1'b0;

    // Continuous contention must alternate MEM, IF, MEM, IF ...
    $display("[TB] back-to-back contention");
    grant_log.delete();
    fork
      repeat (4) applyStimulus(1, 1'($urandom_range(0, 1)), rnd_mem_addr(), 4'($urandom_range(1, 15)), $urandom);
      repeat (4) applyStimulus(0, 0, rnd_if_addr(), 4'hF, 32'h0);
    join
    checkOutput("t3_grant_count", grant_log.size(), 8);
    for (int i = 0; i < grant_log.size() && i < 8; i++)
      checkOutput("t3_grant_alternation", grant_log[i], (i % 2 == 0) ? 1 : 0);

    // Fetch killed by flush in its first BUSY cycle; the redirected fetch is served next.
    $display("[TB] flush of an in-flight fetch");
    if_addr_i = 32'h030; if_req_i = 1'b1;
    waitBusReq(1'b1, "t4_bus_started");
    e.rdata = rom(32'h0A4); e.err = 1'b0; e.chk_data = 1'b1;
    if_exp.push_back(e);
    flush_i = 1'b1; if_addr_i = 32'h0A4;
    @(posedge clk); #1 flush_i = 1'b0;
    waitBusReq(1'b0, "t4_bus_completed");
    checkOutput("t4_discarded_done", {if_ack_o, if_err_o, if_rdata_o}, {2'b00, model_if_rdata});
    model_if_rdata = rom(32'h0A4);
    waitAck(0);

    // Fetch abandoned by dropping the request while BUSY.
    if_addr_i = 32'h050; if_req_i = 1'b1;
    waitBusReq(1'b1, "t4b_bus_started");
    @(posedge clk); #1 if_req_i = 1'b0;
    waitBusReq(1'b0, "t4b_bus_completed");
    checkOutput("t4b_dropped_done", {if_ack_o, if_rdata_o}, {1'b0, model_if_rdata});

    // A flush in IDLE holds off the fetch grant.
    e.rdata = rom(32'h0B0); e.err = 1'b0; e.chk_data = 1'b1;
    if_exp.push_back(e);
    if_addr_i = 32'h0B0; if_req_i = 1'b1; flush_i = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checkOutput("t4_flush_blocks_grant", bus_req_o, 0);
    end
    @(posedge clk); #1 flush_i = 1'b0;
    model_if_rdata = rom(32'h0B0);
    waitAck(0);

    // Watchdog: silent slave aborts after 16 BUSY cycles; an ack in cycle 16 still wins.
    $display("[TB] watchdog timeout");
    applyStimulus(1, 0, 32'h2F00, 4'hF, 32'h0);
    checkOutput("t5_timeout_busy_len", last_len, TIMEOUT);
    applyStimulus(1, 0, 32'h2E00, 4'hF, 32'h0);
    checkOutput("t5_late_ack_busy_len", last_len, TIMEOUT);
    applyStimulus(0, 0, 32'h0F00, 4'hF, 32'h0);
    checkOutput("t5_if_timeout_busy_len", last_len, TIMEOUT);

    // Randomized traffic with independent idle gaps on each requester.
    $display("[TB] randomized traffic");
    fork
      repeat (20) begin
        repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        applyStimulus(0, 0, rnd_if_addr(), 4'hF, 32'h0);
      end
      repeat (20) begin
        repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
        applyStimulus(1, 1'($urandom_range(0, 1)), rnd_mem_addr(), 4'($urandom_range(1, 15)), $urandom);
      end
    join

    // Asynchronous reset in the middle of a transaction.
    $display("[TB] reset during BUSY");
    mem_we_i = 1'b0; mem_addr_i = 32'h2F04; mem_sel_i = 4'hF; mem_req_i = 1'b1;
    waitBusReq(1'b1, "t6_bus_started");
    repeat (3) @(negedge clk);
    rst = 1'b1; mem_req_i = 1'b0;
    #1;
    checkAllZero("t6_async_reset");
    @(posedge clk); #1;
    @(posedge clk); #1 rst = 1'b0;
    model_if_rdata = '0;
    applyStimulus(1, 0, 32'h2000, 4'hF, 32'h0);
    applyStimulus(0, 0, 32'h0C8, 4'hF, 32'h0);

    repeat (3) @(negedge clk);
    checkOutput("if_exp_drained", if_exp.size(), 0);
    checkOutput("mem_exp_drained", mem_exp.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
